rr_arb_mux2: RTL and testbench
==============================

# rr_arb_mux2

Two-requester round-robin arbiter that owns the select of a shared 2:1 message multiplexer and feeds a single registered output channel. Sits in front of any single-ported downstream resource that two producers must share. All channels use val/rdy handshakes. The output stage is a one-entry pipeline buffer, so grant decisions are registered and the output is glitch-free.

## Interface
- `NBITS`, 32, message width in bits (≥1)
- `clk` in 1 — clock, all state updates on rising edge
- `rst` in 1 — reset, asynchronous, active-high
- `in0_val` in 1 — requester 0 message valid
- `in0_rdy` out 1 — requester 0 accepted this cycle
- `in0_msg` in NBITS — requester 0 message
- `in0_last` in 1 — final beat of requester 0 packet (used only with lock feature)
- `in1_val`, `in1_rdy`, `in1_msg`, `in1_last` — same for requester 1
- `out_val` out 1 — output buffer holds a message
- `out_rdy` in 1 — downstream accepts
- `out_msg` out NBITS — buffered message
- `out_src` out 1 — index of requester that supplied `out_msg`

## Operation
- State: `buf_full`, `buf_msg`, `buf_src`, `prio` (favoured requester), plus `lock_act`/`lock_own` when lock is compiled in.
- `can_load = !buf_full | out_rdy` (buffer empty, or draining this cycle).
- Grant (combinational, when `can_load`): only one valid -> that one; both valid -> `prio`; none -> no grant. Lock overrides (see Configuration).
- Exactly one of `in0_rdy`/`in1_rdy` high at most; `inN_rdy = can_load & grant==N & inN_val`. Never assert rdy to an invalid requester.
- On transfer from N: `buf_msg <= inN_msg` (via the mux, select = grant), `buf_src <= N`, `buf_full <= 1`, `prio <= ~N`.
- On dequeue without load: `buf_full <= 0`; `buf_msg` holds.
- `prio` changes only on transfer; a lone requester keeps winning while the other is idle.
- Reset (any cycle, asynchronous): `buf_full=0`, `out_val=0`, `out_msg=0`, `out_src=0`, `prio=0`, `lock_act=0`, `lock_own=0`; all `inN_rdy=0` while `rst` high. In-flight buffered message is discarded.

## Timing
- Latency 1 cycle: message accepted at edge k appears on `out_val`/`out_msg` in cycle k+1.
- Throughput 1 message/cycle sustained when `out_rdy` held high.
- `out_rdy` low with buffer full: both `inN_rdy` low; `out_msg`, `out_src` stable until dequeue.
- Simultaneous dequeue and load in same cycle: buffer stays full with new message, no bubble.
- `out_val` and `out_msg` depend only on registers; `inN_rdy` depends combinationally on `out_rdy`, `inN_val`, state.
- Both requesters continuously valid: grants strictly alternate 0,1,0,1... starting with 0 after reset.

## Configuration
- `RR_ARB_MUX2_LOCK_EN` defined: packet lock. Transfer from N with `inN_last=0` sets `lock_act=1`, `lock_own=N`; while locked, grant forced to `lock_own` (other requester never granted even if `lock_own` idle). Transfer from owner with `last=1` clears lock and sets `prio <= ~N`. `prio` not updated on non-last beats.
- Undefined: `inN_last` ignored, no lock state, every beat arbitrated independently. `last` ports remain present in both builds.

## Structure
- Package `rr_arb_mux2_pkg`: `typedef logic [0:0] src_t`, constants `SRC_IN0 = 1'b0`, `SRC_IN1 = 1'b1`, reset constant for `prio`.
- One sub-module: `mux2_nbits` (parameter `NBITS`; `in0`, `in1`, `sel`, `out`), instantiated once for the message path; `buf_src` and grant logic stay in the top.

## Test plan
- Reset mid-stream: buffer full with 0xA5, assert `rst` between edges -> `out_val` drops immediately, `prio=0`, next grant with both valid goes to in0.
- Both valid, `out_rdy=1`, in0 msgs 0x10,0x11, in1 msgs 0x20,0x21 -> outputs 0x10,0x20,0x11,0x21 on consecutive cycles, `out_src` 0,1,0,1.
- Only in1 valid for 3 cycles -> three in1 grants, no bubbles; then both valid -> in0 granted first.
- Backpressure: buffer full, `out_rdy=0` for 4 cycles, both valid -> no `inN_rdy`, `out_msg` stable; `out_rdy=1` -> dequeue and reload same edge.
- Lock (macro on): in1 sends 3 beats, `last` on beat 3, in0 valid throughout -> in1,in1,in1 then in0; in0 never granted during the packet even when in1 idles one cycle.
- Lock (macro off), same stimulus -> grants alternate per beat, `last` ignored.

Source files
------------

// File: rtl/rr_arb_mux2_pkg.sv
// rr_arb_mux2_pkg
// Shared types and constants for the two-requester round-robin arbiter/mux.
//   src_t      : requester index (0 = in0, 1 = in1)
//   SRC_IN0/1  : named requester indices
//   PRIO_RST   : requester favoured after reset
//   other_src  : the opposite requester of a given index
package rr_arb_mux2_pkg;

  typedef logic [0:0] src_t;

  localparam src_t SRC_IN0  = 1'b0;
  localparam src_t SRC_IN1  = 1'b1;
  localparam src_t PRIO_RST = SRC_IN0;

  function automatic src_t other_src(input src_t s);
    return ~s;
  endfunction

endpackage

// File: rtl/mux2_nbits.sv
// mux2_nbits
// Plain NBITS-wide 2:1 multiplexer used on the message path.
//   in0, in1 : data inputs
//   sel      : 0 selects in0, 1 selects in1
//   out      : selected data
module mux2_nbits #(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             sel,
  output logic [NBITS-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/rr_arb_mux2.sv
// rr_arb_mux2
// Two-requester round-robin arbiter driving the select of a shared 2:1
// message mux, feeding a one-entry registered output buffer. All channels
// use val/rdy handshakes; out_val/out_msg/out_src come straight from flops.
//
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   in0_val/in0_rdy/in0_msg/in0_last : requester 0 channel
//   in1_val/in1_rdy/in1_msg/in1_last : requester 1 channel
//   out_val/out_rdy/out_msg        : buffered output channel
//   out_src                        : requester that supplied out_msg
//
// Build option: define RR_ARB_MUX2_LOCK_EN to enable packet lock. A beat
// with last=0 locks the grant to its requester until that requester sends
// a beat with last=1. Without the macro the last inputs are ignored and
// every beat is arbitrated on its own.
module rr_arb_mux2
  import rr_arb_mux2_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_val,
  output logic             in0_rdy,
  input  logic [NBITS-1:0] in0_msg,
  input  logic             in0_last,
  input  logic             in1_val,
  output logic             in1_rdy,
  input  logic [NBITS-1:0] in1_msg,
  input  logic             in1_last,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_msg,
  output src_t             out_src
);

  logic             vld_p1;
  logic [NBITS-1:0] buf_msg_p1;
  src_t             buf_src_p1;
  src_t             prio;

  logic             can_load;
  logic             req;
  logic             xfer;
  src_t             gnt;
  logic [NBITS-1:0] mux_msg;

`ifdef RR_ARB_MUX2_LOCK_EN
  logic lock_act;
  src_t lock_own;
  logic gnt_last;
`else
  // last only matters for packet lock; fold it away here.
  logic unused_last;
  assign unused_last = in0_last ^ in1_last;
`endif

  // ---- stage p0: arbitration and message select ----
  // The buffer can accept when it is empty or is being drained this cycle.
  assign can_load = ~vld_p1 | out_rdy;

  always_comb begin
    gnt = prio;
    req = 1'b0;
    if (in0_val && in1_val) begin
      gnt = prio;
      req = 1'b1;
    end else if (in0_val) begin
      gnt = SRC_IN0;
      req = 1'b1;
    end else if (in1_val) begin
      gnt = SRC_IN1;
      req = 1'b1;
    end
`ifdef RR_ARB_MUX2_LOCK_EN
    // A locked packet owns the mux even while its requester is idle.
    if (lock_act) begin
      gnt = lock_own;
      req = (lock_own == SRC_IN1) ? in1_val : in0_val;
    end
`endif
  end

  // rdy is held low throughout reset so nothing is accepted.
  assign xfer    = req & can_load & ~rst;
  assign in0_rdy = xfer & (gnt == SRC_IN0);
  assign in1_rdy = xfer & (gnt == SRC_IN1);

`ifdef RR_ARB_MUX2_LOCK_EN
  assign gnt_last = (gnt == SRC_IN1) ? in1_last : in0_last;
`endif

  mux2_nbits #(
    .NBITS (NBITS)
  ) u_msg_mux (
    .in0 (in0_msg),
    .in1 (in1_msg),
    .sel (gnt),
    .out (mux_msg)
  );

  // ---- stage p1: output buffer and arbitration state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      buf_msg_p1 <= '0;
      buf_src_p1 <= SRC_IN0;
      prio       <= PRIO_RST;
`ifdef RR_ARB_MUX2_LOCK_EN
      lock_act   <= 1'b0;
      lock_own   <= SRC_IN0;
`endif
    end else begin
      if (xfer) begin
        // Load wins over dequeue: a simultaneous drain and load keeps
        // the buffer full with no bubble.
        vld_p1     <= 1'b1;
        buf_msg_p1 <= mux_msg;
        buf_src_p1 <= gnt;
`ifdef RR_ARB_MUX2_LOCK_EN
        // Priority only rotates at packet boundaries.
        if (gnt_last) begin
          lock_act <= 1'b0;
          prio     <= other_src(gnt);
        end else begin
          lock_act <= 1'b1;
          lock_own <= gnt;
        end
`else
        prio       <= other_src(gnt);
`endif
      end else if (out_rdy) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_val = vld_p1;
  assign out_msg = buf_msg_p1;
  assign out_src = buf_src_p1;

endmodule

// File: tb/tb_rr_arb_mux2.sv
`timescale 1ns/1ps
module tb_rr_arb_mux2;

  localparam int NBITS = 32;
`ifdef RR_ARB_MUX2_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in0_val, in0_rdy, in0_last;
  logic             in1_val, in1_rdy, in1_last;
  logic [NBITS-1:0] in0_msg, in1_msg;
  logic             out_val, out_rdy;
  logic [NBITS-1:0] out_msg;
  logic [0:0]       out_src;

  always #5 clk = ~clk;

  rr_arb_mux2 #(.NBITS(NBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in0_val  (in0_val),
    .in0_rdy  (in0_rdy),
    .in0_msg  (in0_msg),
    .in0_last (in0_last),
    .in1_val  (in1_val),
    .in1_rdy  (in1_rdy),
    .in1_msg  (in1_msg),
    .in1_last (in1_last),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .out_src  (out_src)
  );

  typedef logic [NBITS:0] beat_t;  // {last, msg}
  typedef logic [NBITS:0] item_t;  // {src, msg}

  beat_t q0[$], q1[$];      // pending messages per producer
  item_t expq[$];           // scoreboard: expected output order
  item_t seen[$];           // what the monitor observed
  item_t exs[$];            // directed expectation list
  item_t mon_e;

  int checks = 0;
  int errors = 0;

  // Reference model: buffer occupancy, who won last, open packet owner.
  bit m_full, m_lock, m_owner, m_lastwin;

  function automatic beat_t mk(input bit last, input logic [NBITS-1:0] m);
    return {last, m};
  endfunction

  function automatic item_t it(input bit s, input logic [NBITS-1:0] m);
    return {s, m};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_full    = 1'b0;
    m_lock    = 1'b0;
    m_owner   = 1'b0;
    m_lastwin = 1'b1;  // so requester 0 is favoured first
  endtask

  task automatic drive(input bit w0, input bit w1, input bit ordy);
    in0_val = w0 && (q0.size() > 0);
    if (q0.size() > 0) {in0_last, in0_msg} = q0[0];
    else begin in0_msg = $urandom; in0_last = 1'($urandom_range(0, 1)); end
    in1_val = w1 && (q1.size() > 0);
    if (q1.size() > 0) {in1_last, in1_msg} = q1[0];
    else begin in1_msg = $urandom; in1_last = 1'($urandom_range(0, 1)); end
    out_rdy = ordy;
  endtask

  // Predict the decision for the coming edge, check rdy, advance the model.
  task automatic model_step();
    bit can, rq, g, lst;
    beat_t b;
    chk("out_val", out_val, m_full);
    can = !m_full || out_rdy;
    rq = 1'b0;
    g  = 1'b0;
    if (can) begin
      if (LOCK && m_lock) begin
        g  = m_owner;
        rq = g ? in1_val : in0_val;
      end else if (in0_val && in1_val) begin
        g  = !m_lastwin;
        rq = 1'b1;
      end else if (in0_val || in1_val) begin
        g  = in1_val;
        rq = 1'b1;
      end
    end
    chk("in0_rdy", in0_rdy, rq && !g);
    chk("in1_rdy", in1_rdy, rq && g);
    if (rq) begin
      if (g) b = q1.pop_front();
      else   b = q0.pop_front();
      expq.push_back(it(g, b[NBITS-1:0]));
      lst = b[NBITS];
      if (LOCK && !lst) begin
        m_lock  = 1'b1;
        m_owner = g;
      end else begin
        m_lock    = 1'b0;
        m_lastwin = g;
      end
      m_full = 1'b1;
    end else if (out_rdy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic cycle(input bit w0, input bit w1, input bit ordy);
    @(posedge clk);
    #1;
    drive(w0, w1, ordy);
    @(negedge clk);
    model_step();
  endtask

  task automatic check_seen(input string name);
    #1;
    chk({name, "_count"}, seen.size(), exs.size());
    for (int i = 0; i < exs.size() && i < seen.size(); i++)
      chk(name, seen[i], exs[i]);
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands off a message.
  always @(negedge clk) begin
    if (!rst && out_val && out_rdy) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_msg);
      end else begin
        mon_e = expq.pop_front();
        chk("out_msg", out_msg, mon_e[NBITS-1:0]);
        chk("out_src", out_src, mon_e[NBITS]);
      end
      seen.push_back({out_src, out_msg});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    m_reset();
    in0_val = 1'b1; in1_val = 1'b1; out_rdy = 1'b1;
    in0_msg = 'h1;  in1_msg = 'h2;  in0_last = 1'b1; in1_last = 1'b1;
    #12;
    chk("rst_out_val", out_val, 0);
    chk("rst_out_msg", out_msg, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_in0_rdy", in0_rdy, 0);
    chk("rst_in1_rdy", in1_rdy, 0);
    in0_val = 1'b0; in1_val = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;

    // Both valid: strict alternation starting at in0.
    seen.delete();
    q0 = {mk(1, 'h10), mk(1, 'h11)};
    q1 = {mk(1, 'h20), mk(1, 'h21)};
    repeat (4) cycle(1, 1, 1);
    cycle(0, 0, 1);
    exs = {it(0, 'h10), it(1, 'h20), it(0, 'h11), it(1, 'h21)};
    check_seen("alternate");

    // Lone requester keeps winning, then in0 favoured.
    seen.delete();
    q1 = {mk(1, 'h50), mk(1, 'h51), mk(1, 'h52)};
    repeat (3) cycle(0, 1, 1);
    q0 = {mk(1, 'h60)};
    q1 = {mk(1, 'h53)};
    repeat (2) cycle(1, 1, 1);
    cycle(0, 0, 1);
    exs = {it(1, 'h50), it(1, 'h51), it(1, 'h52), it(0, 'h60), it(1, 'h53)};
    check_seen("lone_in1");

    // Backpressure: output held, no rdy, then drain and reload same edge.
    seen.delete();
    q0 = {mk(1, 'h70), mk(1, 'h71)};
    q1 = {mk(1, 'h80), mk(1, 'h81)};
    cycle(1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0);
      chk("bp_msg", out_msg, 'h70);
      chk("bp_src", out_src, 0);
    end
    repeat (3) cycle(1, 1, 1);
    cycle(0, 0, 1);
    exs = {it(0, 'h70), it(1, 'h80), it(0, 'h71), it(1, 'h81)};
    check_seen("backpressure");

    // Reset mid-stream with 0xA5 buffered.
    q0 = {mk(1, 'hA5)};
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("pre_rst_msg", out_msg, 'hA5);
    @(posedge clk);
    #1;
    q0 = {mk(1, 'hB0)};
    q1 = {mk(1, 'hC0)};
    drive(1, 1, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_val", out_val, 0);
    chk("mid_rst_out_msg", out_msg, 0);
    chk("mid_rst_in0_rdy", in0_rdy, 0);
    chk("mid_rst_in1_rdy", in1_rdy, 0);
    m_reset();
    expq.delete();
    seen.delete();
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    model_step();
    cycle(1, 1, 1);
    repeat (2) cycle(0, 0, 1);
    exs = {it(0, 'hB0), it(1, 'hC0)};
    check_seen("after_rst");

    // Packet from in1 with in0 waiting; in1 idles one cycle mid-packet.
    seen.delete();
    q1 = {mk(0, 'hD1), mk(0, 'hD2), mk(1, 'hD3)};
    q0 = {mk(1, 'hC1)};
    cycle(0, 1, 1);
    cycle(1, 1, 1);
    cycle(1, 0, 1);
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    repeat (2) cycle(0, 0, 1);
    if (LOCK) exs = {it(1, 'hD1), it(1, 'hD2), it(1, 'hD3), it(0, 'hC1)};
    else      exs = {it(1, 'hD1), it(0, 'hC1), it(1, 'hD2), it(1, 'hD3)};
    check_seen("packet");

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      while (q0.size() < 3) q0.push_back(mk(1'($urandom_range(0, 3) != 0), NBITS'($urandom)));
      while (q1.size() < 3) q1.push_back(mk(1'($urandom_range(0, 3) != 0), NBITS'($urandom)));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0));
    end

    // Drain; close any open packet so the other side can finish.
    guard = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_full) && guard < 200) begin
      if (m_lock) begin
        if (m_owner && q1.size() == 0) q1.push_back(mk(1, NBITS'($urandom)));
        if (!m_owner && q0.size() == 0) q0.push_back(mk(1, NBITS'($urandom)));
      end
      cycle(1, 1, 1);
      guard++;
    end
    chk("drain_done", guard < 200, 1);
    #1;
    chk("scoreboard_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
